// File: rtl/lane_traffic_controller.sv
// Lane traffic controller: a move-tick counter and a one-lane-per-cycle sweep.
// The optional LANE_SPEED_SCALING_EN macro lets i_Score shorten the tick period.
module lane_traffic_controller #(
    parameter int NB_LANES       = 4,
    parameter int X_WIDTH        = 10,
    parameter int STEP_WIDTH     = 3,
    parameter int H_VISIBLE_AREA = 640,
    parameter int TILE_SIZE      = 32,
    parameter int BASE_PERIOD    = 781250,
    parameter int CNT_WIDTH      = 20
) (
    input  logic                           i_Clk,
    input  logic                           i_Reset,
    input  logic                           i_Enable,
    input  logic [NB_LANES-1:0]            i_Reverse,
    input  logic                           i_Level_Up,
    input  logic [5:0]                     i_Score,
    input  logic [NB_LANES*STEP_WIDTH-1:0] i_Step,
    output logic [NB_LANES*X_WIDTH-1:0]    o_Car_X,
    output logic                           o_Tick,
    output logic                           o_Busy
);

    localparam int X_MAX = H_VISIBLE_AREA - TILE_SIZE;
    localparam int IDX_W = (NB_LANES > 1) ? $clog2(NB_LANES) : 1;

    localparam logic [CNT_WIDTH-1:0] P0 = CNT_WIDTH'(BASE_PERIOD);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NB_LANES - 1);

    if ((NB_LANES * TILE_SIZE > X_MAX) || ((BASE_PERIOD >> 3) <= NB_LANES)) begin : g_bad_params
        $error("lane_traffic_controller: parameter constraints violated");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t                          r_State, next_state;
    logic [IDX_W-1:0]                r_Idx, next_idx;
    logic                            r_Pending, next_pending;
    logic                            start_sweep;
    logic [CNT_WIDTH-1:0]            r_Count;
    logic [CNT_WIDTH-1:0]            r_Period;
    logic                            tick_fire;
    logic [X_WIDTH-1:0]              r_X [NB_LANES];
    logic [NB_LANES-1:0]             r_Dir;
    logic [NB_LANES-1:0]             r_Snap_Dir;
    logic [NB_LANES*STEP_WIDTH-1:0]  r_Snap_Step;
    logic                            r_First;
    logic [X_WIDTH-1:0]              cur_x, new_x;
    logic [STEP_WIDTH-1:0]           cur_step;
    logic                            cur_dir;
    logic [X_WIDTH:0]                sum;

`ifdef LANE_SPEED_SCALING_EN
    localparam logic [CNT_WIDTH-1:0] P1 = CNT_WIDTH'(BASE_PERIOD >> 1);
    localparam logic [CNT_WIDTH-1:0] P2 = CNT_WIDTH'(BASE_PERIOD >> 2);
    localparam logic [CNT_WIDTH-1:0] P3 = CNT_WIDTH'(BASE_PERIOD >> 3);

    // Higher scores select a shorter tick period
    always_ff @(posedge i_Clk) begin
        if (i_Reset)               r_Period <= P0;
        else if (i_Score < 6'd4)   r_Period <= P0;
        else if (i_Score < 6'd7)   r_Period <= P1;
        else if (i_Score < 6'd10)  r_Period <= P2;
        else                       r_Period <= P3;
    end
`else
    logic unused_score;
    assign unused_score = ^i_Score;

    // Fixed tick period
    always_ff @(posedge i_Clk) begin
        r_Period <= P0;
    end
`endif

    assign tick_fire = i_Enable && (r_Count >= r_Period - 1'b1);

    // Tick counter advances only while enabled
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_Count <= '0;
            o_Tick  <= 1'b0;
        end else begin
            o_Tick <= tick_fire;
            if (i_Enable)
                r_Count <= tick_fire ? '0 : r_Count + 1'b1;
        end
    end

    // FSM state, sweep index and one-deep pending tick
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_State   <= IDLE;
            r_Idx     <= '0;
            r_Pending <= 1'b0;
        end else begin
            r_State   <= next_state;
            r_Idx     <= next_idx;
            r_Pending <= next_pending;
        end
    end

    // Next-state logic: ticks start sweeps, a tick mid-sweep is queued once
    always_comb begin
        next_state   = r_State;
        next_idx     = r_Idx;
        next_pending = r_Pending;
        start_sweep  = 1'b0;
        unique case (r_State)
            IDLE: begin
                if (tick_fire) begin
                    next_state  = SWEEP;
                    next_idx    = '0;
                    start_sweep = 1'b1;
                end
            end
            SWEEP: begin
                if (r_Idx == LAST_IDX) begin
                    if (r_Pending || tick_fire) begin
                        next_idx     = '0;
                        start_sweep  = 1'b1;
                        next_pending = r_Pending && tick_fire;
                    end else begin
                        next_state = IDLE;
                    end
                end else begin
                    next_idx = r_Idx + 1'b1;
                    if (tick_fire)
                        next_pending = 1'b1;
                end
            end
        endcase
    end

    // New position of the lane addressed by the sweep index
    always_comb begin
        cur_x    = r_X[r_Idx];
        cur_step = r_Snap_Step[r_Idx*STEP_WIDTH +: STEP_WIDTH];
        cur_dir  = r_Snap_Dir[r_Idx];
        sum      = {1'b0, cur_x} + (X_WIDTH+1)'(cur_step);
        new_x    = cur_x;
        if (cur_step == '0)
            new_x = cur_x;
        else if (!cur_dir)
            new_x = (sum >= (X_WIDTH+1)'(X_MAX)) ? '0 : sum[X_WIDTH-1:0];
        else if (cur_x == '0)
            new_x = X_WIDTH'(X_MAX);
        else if (cur_x < X_WIDTH'(cur_step))
            new_x = '0;
        else
            new_x = cur_x - X_WIDTH'(cur_step);
    end

    // Lane positions, committed directions and sweep snapshots
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            for (int k = 0; k < NB_LANES; k++)
                r_X[k] <= X_WIDTH'(k * TILE_SIZE);
            r_Dir       <= '0;
            r_First     <= 1'b1;
            r_Snap_Dir  <= '0;
            r_Snap_Step <= '0;
        end else begin
            r_First <= 1'b0;
            if (r_First || i_Level_Up)
                r_Dir <= i_Reverse;
            if (start_sweep) begin
                r_Snap_Dir  <= r_Dir;
                r_Snap_Step <= i_Step;
            end
            if (r_State == SWEEP)
                r_X[r_Idx] <= new_x;
        end
    end

    for (genvar k = 0; k < NB_LANES; k++) begin : g_pack
        assign o_Car_X[k*X_WIDTH +: X_WIDTH] = r_X[k];
    end

    assign o_Busy = (r_State == SWEEP);

endmodule
